// File: rtl/lfsr_period_gen_if.sv
// Bundle of seed/control inputs and state/measurement outputs for lfsr_period_gen.
// The master drives seed/load/en; the slave (the generator) drives everything else.
interface lfsr_period_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] data;
  logic             out;
  logic             ready;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic [15:0]      wraps;
  logic             lockup;

  modport master (
    output seed, load, en,
    input  data, out, ready, period, period_valid, wraps, lockup
  );

  modport slave (
    input  seed, load, en,
    output data, out, ready, period, period_valid, wraps, lockup
  );
endinterface

// File: rtl/lfsr_period_gen.sv
// Fibonacci LFSR with exact period measurement: counts steps until the state returns
// to the loaded seed, and flags (optionally repairs) the all-zero lock-up seed.
module lfsr_period_gen #(
  parameter int             WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
  parameter bit             ZERO_SUB = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_period_gen_if.slave  bus
);

  generate
    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_period_gen: WIDTH must be in 3..32");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
      $error("lfsr_period_gen: TAPS[WIDTH-1] must be 1");
    end
  endgenerate

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] seed_ref_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] period_reg;
  logic             ready_reg;
  logic             period_valid_reg;
  logic [15:0]      wraps_reg;
  logic             lockup_reg;

  logic [WIDTH-1:0] tap_bits;
  logic             feedback;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt_inc;
  logic             seed_zero;
  logic             wrap_hit;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_taps
      assign tap_bits[gi] = data_reg[gi] & TAPS[gi];
    end
  endgenerate

  assign feedback  = ^tap_bits;
  assign data_next = {data_reg[WIDTH-2:0], feedback};
  assign seed_zero = (bus.seed == '0);
  assign load_val  = (ZERO_SUB && seed_zero) ? WIDTH'(1) : bus.seed;
  assign cnt_inc   = cnt_reg + WIDTH'(1);
  // The step is a bijection, so the first return to seed_ref closes the cycle exactly.
  assign wrap_hit  = (data_next == seed_ref_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg         <= '0;
      seed_ref_reg     <= '0;
      cnt_reg          <= '0;
      period_reg       <= '0;
      ready_reg        <= 1'b0;
      period_valid_reg <= 1'b0;
      wraps_reg        <= '0;
      lockup_reg       <= 1'b0;
    end else begin
      period_valid_reg <= 1'b0;
      if (bus.load) begin
        data_reg     <= load_val;
        seed_ref_reg <= load_val;
        cnt_reg      <= '0;
        ready_reg    <= 1'b1;
        period_reg   <= '0;
        wraps_reg    <= '0;
        lockup_reg   <= seed_zero;
      end else if (bus.en && ready_reg) begin
        data_reg <= data_next;
        if (wrap_hit) begin
          period_reg       <= cnt_inc;
          period_valid_reg <= 1'b1;
          cnt_reg          <= '0;
          if (wraps_reg != 16'hFFFF) begin
            wraps_reg <= wraps_reg + 16'd1;
          end
        end else begin
          cnt_reg <= cnt_inc;
        end
        // Without substitution zero maps only to zero, so this tracks the stuck state.
        if (!ZERO_SUB) begin
          lockup_reg <= (data_next == '0);
        end
      end
    end
  end

  assign bus.data         = data_reg;
  assign bus.out          = data_reg[WIDTH-1];
  assign bus.ready        = ready_reg;
  assign bus.period       = period_reg;
  assign bus.period_valid = period_valid_reg;
  assign bus.wraps        = wraps_reg;
  assign bus.lockup       = lockup_reg;

endmodule
